// File: rtl/div_issue_ctrl_if.sv
// EX-stage / divider / HI-LO signal bundle for div_issue_ctrl.
// slave = controller view, master = surrounding pipeline, divider and HI/LO file.
interface div_issue_ctrl_if;
   logic        ex_div_req;
   logic        ex_div_signed;
   logic [31:0] ex_opa;
   logic [31:0] ex_opb;
   logic        ex_advance;
   logic        flush;
   logic        div_start;
   logic        div_unsigned;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic [63:0] div_result;
   logic        div_done;
   logic        stall_req;
   logic        hilo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        div_timeout;

   modport slave (
      input  ex_div_req, ex_div_signed, ex_opa, ex_opb, ex_advance, flush,
             div_result, div_done,
      output div_start, div_unsigned, div_opa, div_opb, stall_req,
             hilo_we, hi_wdata, lo_wdata, div_timeout
   );

   modport master (
      output ex_div_req, ex_div_signed, ex_opa, ex_opb, ex_advance, flush,
             div_result, div_done,
      input  div_start, div_unsigned, div_opa, div_opb, stall_req,
             hilo_we, hi_wdata, lo_wdata, div_timeout
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: latches operands, stalls EX until done, writes HI/LO.
// Optional DIV_ZERO_FAST_EN: divide-by-zero bypasses the divider and completes in one cycle.
module div_issue_ctrl #(
   parameter int unsigned DIV_CYCLES = 36,
   parameter int unsigned WDOG_SLACK = 4
) (
   input  logic            clock,
   input  logic            reset,
   div_issue_ctrl_if.slave bus
);
   localparam int unsigned WDOG_LIMIT = DIV_CYCLES + WDOG_SLACK;
   localparam int unsigned CW         = $clog2(WDOG_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wdog_cnt;
   logic          wdog_hit;
   logic          fast_zero;
   logic          issue;
   logic          write_nxt;
   logic          timeout_set;
   logic          stall;
   logic          start;

   logic          uns_q;
   logic [31:0]   opa_q;
   logic [31:0]   opb_q;
   logic          we_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          timeout_q;

`ifdef DIV_ZERO_FAST_EN
   assign fast_zero = (bus.ex_opb == '0);
`else
   assign fast_zero = 1'b0;
`endif

   // wdog_cnt counts completed BUSY cycles, so this is the last permitted BUSY cycle
   assign wdog_hit = (wdog_cnt == CW'(WDOG_LIMIT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      stall       = 1'b0;
      start       = 1'b0;
      issue       = 1'b0;
      write_nxt   = 1'b0;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            stall = bus.ex_div_req & ~bus.flush;
            if (bus.ex_div_req && !bus.flush) begin
               issue     = 1'b1;
               write_nxt = fast_zero;
               state_nxt = fast_zero ? DONE : BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            start = 1'b1;
            // flush beats a simultaneous done; done beats the watchdog
            if (bus.flush) begin
               state_nxt = IDLE;
            end else if (bus.div_done) begin
               write_nxt = 1'b1;
               state_nxt = DONE;
            end else if (wdog_hit) begin
               timeout_set = 1'b1;
               state_nxt   = IDLE;
            end
         end
         DONE: begin
            if (bus.ex_advance || bus.flush) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wdog_cnt  <= '0;
         uns_q     <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         we_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_cnt <= (state == BUSY) ? wdog_cnt + CW'(1) : '0;
         we_q     <= write_nxt;
         if (issue) begin
            opa_q <= bus.ex_opa;
            opb_q <= bus.ex_opb;
            uns_q <= ~bus.ex_div_signed;
         end
         if (write_nxt) begin
            if (state == IDLE) begin
               hi_q <= bus.ex_opa;
               lo_q <= '1;
            end else begin
               hi_q <= bus.div_result[63:32];
               lo_q <= bus.div_result[31:0];
            end
         end
         if (timeout_set) timeout_q <= 1'b1;
      end
   end

   assign bus.stall_req    = stall;
   assign bus.div_start    = start;
   assign bus.div_unsigned = uns_q;
   assign bus.div_opa      = opa_q;
   assign bus.div_opb      = opb_q;
   assign bus.hilo_we      = we_q;
   assign bus.hi_wdata     = hi_q;
   assign bus.lo_wdata     = lo_q;
   assign bus.div_timeout  = timeout_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider and a quotient/remainder reference model.
module tb_div_issue_ctrl;
   localparam int unsigned DIVC  = 36;
   localparam int unsigned SLACK = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   div_issue_ctrl_if bus();

   div_issue_ctrl #(.DIV_CYCLES(DIVC), .WDOG_SLACK(SLACK)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;
   always @(posedge clock) cyc++;

   function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
      longint la, lb;
      if (b == 32'd0) begin
         hi = a;
         lo = '1;
         return;
      end
      la = sgn ? longint'(signed'(a)) : longint'(a);
      lb = sgn ? longint'(signed'(b)) : longint'(b);
      lo = 32'(la / lb);
      hi = 32'(la % lb);
   endfunction

   // Divider: done appears DIVC cycles after start rises, computed from the operands it was handed
   bit          stuck   = 1'b0;
   int          run_cnt = 0;
   logic [31:0] dv_hi, dv_lo;
   always @(negedge clock) begin
      if (bus.div_start === 1'b1) begin
         run_cnt++;
         if (run_cnt == int'(DIVC) + 1 && !stuck) begin
            ref_div(!bus.div_unsigned, bus.div_opa, bus.div_opb, dv_hi, dv_lo);
            bus.div_result = {dv_hi, dv_lo};
            bus.div_done   = 1'b1;
         end else begin
            bus.div_done = 1'b0;
         end
      end else begin
         run_cnt      = 0;
         bus.div_done = 1'b0;
      end
   end

   int          we_count   = 0;
   int          rises      = 0;
   int unsigned we_cyc     = 0;
   logic [31:0] we_hi      = '0;
   logic [31:0] we_lo      = '0;
   bit          prev_start = 1'b0;
   always @(negedge clock) begin
      if (bus.hilo_we === 1'b1) begin
         we_count++;
         we_cyc = cyc;
         we_hi  = bus.hi_wdata;
         we_lo  = bus.lo_wdata;
      end
      if (bus.div_start === 1'b1 && !prev_start) rises++;
      prev_start = (bus.div_start === 1'b1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic bit is_fast(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      return (b == 32'd0);
`else
      return 1'b0;
`endif
   endfunction

   // One instruction through EX; upstream bypass operands are scrambled while stalled.
   task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output int stalls, output int wes, output int nrises, output int lat,
                         output logic [31:0] hi, output logic [31:0] lo, output bit req_stall);
      int          we0, r0;
      int unsigned t0;
      we0 = we_count;
      r0  = rises;
      bus.ex_div_req    = 1'b1;
      bus.ex_div_signed = sgn;
      bus.ex_opa        = a;
      bus.ex_opb        = b;
      #1;
      req_stall = (bus.stall_req === 1'b1);
      t0        = cyc;
      stalls    = 0;
      for (int n = 0; n < 200; n++) begin
         step();
         if (bus.stall_req !== 1'b1) break;
         stalls++;
         bus.ex_opa        = $urandom;
         bus.ex_opb        = $urandom;
         bus.ex_div_signed = 1'($urandom);
      end
      repeat (hold) step();
      bus.ex_advance = 1'b1;
      step();
      bus.ex_advance = 1'b0;
      bus.ex_div_req = 1'b0;
      step();
      step();
      wes    = we_count - we0;
      nrises = rises - r0;
      lat    = int'(we_cyc - t0);
      hi     = we_hi;
      lo     = we_lo;
   endtask

   task automatic test_reset();
      bus.ex_div_req = 1'b0; bus.ex_div_signed = 1'b0; bus.ex_opa = '0; bus.ex_opb = '0;
      bus.ex_advance = 1'b0; bus.flush = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({bus.div_start, bus.stall_req, bus.hilo_we, bus.div_timeout, bus.div_unsigned} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {bus.div_start, bus.stall_req, bus.hilo_we, bus.div_timeout, bus.div_unsigned});
      end
      checks++;
      if ({bus.div_opa, bus.div_opb, bus.hi_wdata, bus.lo_wdata} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {bus.div_opa, bus.div_opb, bus.hi_wdata, bus.lo_wdata});
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_divu_basic();
      int st, w, r, l; logic [31:0] h, q; bit rs;
      do_div(1'b0, 32'd100, 32'd7, 0, st, w, r, l, h, q, rs);
      checks++; if (rs !== 1'b1) begin errors++; $display("FAIL req_cycle_stall: got %b expected 1", rs); end
      checks++; if (st !== int'(DIVC) + 1) begin errors++; $display("FAIL stall_len: got %0d expected %0d", st, DIVC + 1); end
      checks++; if (w !== 1) begin errors++; $display("FAIL divu_writes: got %0d expected 1", w); end
      checks++; if (r !== 1) begin errors++; $display("FAIL divu_starts: got %0d expected 1", r); end
      checks++; if (l !== int'(DIVC) + 2) begin errors++; $display("FAIL latency: got %0d expected %0d", l, DIVC + 2); end
      checks++; if (h !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 2", h); end
      checks++; if (q !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 14", q); end
   endtask

   task automatic test_div_signed();
      int st, w, r, l; logic [31:0] h, q; bit rs;
      do_div(1'b1, -32'sd7, 32'd2, 0, st, w, r, l, h, q, rs);
      checks++; if ({h, q} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin errors++;
         $display("FAIL div_neg7_2: got %h expected ffffffff_fffffffd", {h, q}); end
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, st, w, r, l, h, q, rs);
      checks++; if ({h, q} !== {32'h0, 32'h80000000}) begin errors++;
         $display("FAIL div_ovf: got %h expected 00000000_80000000", {h, q}); end
      checks++; if (w !== 1) begin errors++; $display("FAIL div_ovf_writes: got %0d expected 1", w); end
   endtask

   task automatic test_flush();
      int we0, st, w, r, l; logic [31:0] h, q, eh, el; bit rs;
      we0 = we_count;
      bus.ex_div_req = 1'b1; bus.ex_div_signed = 1'b0; bus.ex_opa = 32'd1000; bus.ex_opb = 32'd10;
      step();
      repeat (9) step();
      checks++; if (bus.div_start !== 1'b1) begin errors++; $display("FAIL flush_pre_start: got %b expected 1", bus.div_start); end
      bus.flush = 1'b1; bus.ex_div_req = 1'b0;
      step();
      bus.flush = 1'b0;
      #1;
      checks++; if ({bus.div_start, bus.stall_req} !== 2'b00) begin errors++;
         $display("FAIL flush_start_drop: got %b expected 00", {bus.div_start, bus.stall_req}); end
      step(); step();
      checks++; if (we_count !== we0) begin errors++; $display("FAIL flush_no_write: got %0d expected %0d", we_count, we0); end
      ref_div(1'b1, -32'sd1000, 32'd7, eh, el);
      do_div(1'b1, -32'sd1000, 32'd7, 1, st, w, r, l, h, q, rs);
      checks++; if ({h, q, w} !== {eh, el, 32'd1}) begin errors++;
         $display("FAIL flush_reissue: got %h/%h x%0d expected %h/%h x1", h, q, w, eh, el); end
   endtask

   task automatic test_flush_on_done();
      int we0; bit found;
      we0   = we_count;
      found = 1'b0;
      bus.ex_div_req = 1'b1; bus.ex_div_signed = 1'b0; bus.ex_opa = 32'd77; bus.ex_opb = 32'd5;
      step();
      for (int n = 0; n < 200; n++) begin
         @(negedge clock); #1;
         if (bus.div_done === 1'b1) begin found = 1'b1; break; end
      end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0; bus.ex_div_req = 1'b0;
      step(); step();
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL fod_done_seen: got %b expected 1", found); end
      checks++; if (we_count !== we0) begin errors++; $display("FAIL fod_no_write: got %0d expected %0d", we_count, we0); end
      checks++; if (bus.div_start !== 1'b0) begin errors++; $display("FAIL fod_idle: got %b expected 0", bus.div_start); end
   endtask

   task automatic test_hold_done();
      int st, w, r, l; logic [31:0] h, q, eh, el; bit rs;
      ref_div(1'b0, 32'd123456, 32'd321, eh, el);
      do_div(1'b0, 32'd123456, 32'd321, 5, st, w, r, l, h, q, rs);
      checks++; if (w !== 1) begin errors++; $display("FAIL hold_writes: got %0d expected 1", w); end
      checks++; if (r !== 1) begin errors++; $display("FAIL hold_starts: got %0d expected 1", r); end
      checks++; if ({h, q} !== {eh, el}) begin errors++; $display("FAIL hold_result: got %h expected %h", {h, q}, {eh, el}); end
   endtask

   task automatic test_div_zero();
      int st, w, r, l; logic [31:0] h, q; bit rs; bit fz;
      fz = is_fast(32'd0);
      do_div(1'b1, 32'd5, 32'd0, 2, st, w, r, l, h, q, rs);
      checks++; if ({h, q} !== {32'd5, 32'hFFFFFFFF}) begin errors++;
         $display("FAIL dz_result: got %h expected 00000005_ffffffff", {h, q}); end
      checks++; if (w !== 1) begin errors++; $display("FAIL dz_writes: got %0d expected 1", w); end
      checks++; if (l !== (fz ? 1 : int'(DIVC) + 2)) begin errors++;
         $display("FAIL dz_latency: got %0d expected %0d", l, fz ? 1 : int'(DIVC) + 2); end
      checks++; if (r !== (fz ? 0 : 1)) begin errors++; $display("FAIL dz_starts: got %0d expected %0d", r, fz ? 0 : 1); end
   endtask

   task automatic test_random();
      int st, w, r, l, kind; logic [31:0] a, b, h, q, eh, el; bit rs, sgn, fz;
      for (int i = 0; i < 16; i++) begin
         sgn  = 1'($urandom);
         a    = $urandom;
         kind = int'($urandom_range(0, 5));
         case (kind)
            0:       b = 32'd0;
            1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2:       b = $urandom_range(1, 20);
            default: b = $urandom;
         endcase
         fz = is_fast(b);
         ref_div(sgn, a, b, eh, el);
         do_div(sgn, a, b, int'($urandom_range(0, 3)), st, w, r, l, h, q, rs);
         checks++; if ({h, q} !== {eh, el}) begin errors++;
            $display("FAIL rnd_result[%0d]: got %h expected %h (a=%h b=%h s=%b)", i, {h, q}, {eh, el}, a, b, sgn); end
         checks++; if (w !== 1 || l !== (fz ? 1 : int'(DIVC) + 2)) begin errors++;
            $display("FAIL rnd_write[%0d]: got x%0d lat %0d expected x1 lat %0d", i, w, l, fz ? 1 : int'(DIVC) + 2); end
      end
   endtask

   task automatic test_timeout();
      int we0, n, st, w, r, l; bit early; logic [31:0] h, q; bit rs;
      we0   = we_count;
      early = 1'b0;
      n     = 0;
      stuck = 1'b1;
      bus.ex_div_req = 1'b1; bus.ex_div_signed = 1'b0; bus.ex_opa = 32'd9; bus.ex_opb = 32'd3;
      step();
      for (int k = 0; k < 200; k++) begin
         if (bus.div_start !== 1'b1) break;
         n++;
         if (bus.div_timeout !== 1'b0) early = 1'b1;
         step();
      end
      bus.ex_div_req = 1'b0;
      stuck = 1'b0;
      #1;
      checks++; if (n !== int'(DIVC + SLACK)) begin errors++; $display("FAIL wdog_busy_len: got %0d expected %0d", n, DIVC + SLACK); end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b expected 0", early); end
      checks++; if (bus.div_timeout !== 1'b1) begin errors++; $display("FAIL wdog_flag: got %b expected 1", bus.div_timeout); end
      checks++; if ({bus.stall_req, we_count - we0} !== {1'b0, 32'd0}) begin errors++;
         $display("FAIL wdog_idle: got stall %b writes %0d expected 0/0", bus.stall_req, we_count - we0); end
      do_div(1'b0, 32'd9, 32'd3, 0, st, w, r, l, h, q, rs);
      checks++; if ({bus.div_timeout, h, q} !== {1'b1, 32'd0, 32'd3}) begin errors++;
         $display("FAIL wdog_sticky: got %b %h/%h expected 1 00000000/00000003", bus.div_timeout, h, q); end
   endtask

   task automatic test_reset_mid_op();
      bus.ex_div_req = 1'b1; bus.ex_div_signed = 1'b1; bus.ex_opa = 32'hDEAD0001; bus.ex_opb = 32'd3;
      step();
      repeat (5) step();
      bus.ex_div_req = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.div_start, bus.stall_req, bus.hilo_we, bus.div_timeout, bus.div_unsigned} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_ctrl: got %b expected 00000",
                  {bus.div_start, bus.stall_req, bus.hilo_we, bus.div_timeout, bus.div_unsigned});
      end
      checks++;
      if ({bus.div_opa, bus.div_opb, bus.hi_wdata, bus.lo_wdata} !== 128'd0) begin
         errors++;
         $display("FAIL midreset_data: got %h expected 0", {bus.div_opa, bus.div_opb, bus.hi_wdata, bus.lo_wdata});
      end
      step(); step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_div_signed();
      test_flush();
      test_flush_on_done();
      test_hold_done();
      test_div_zero();
      test_random();
      test_timeout();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
